// File: rtl/hi_lo_muldiv_unit.sv
// HI/LO registers with MTHI/MTLO and iterative mul/div; results land WIDTH+1 cycles after accept, start ignored while busy.
// Define HI_LO_MULDIV_MADD_EN to enable MADD/MADDU accumulate into {hi,lo}.
module hi_lo_muldiv_unit #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   dsr;
  logic               is_div, is_acc, neg_res, neg_rem, dz;

  logic               op_mul, op_div, op_sgn, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;

  always_comb begin
    op_div = (op[2:1] == 2'b10);
`ifdef HI_LO_MULDIV_MADD_EN
    op_mul = (op[2:1] == 2'b01) || (op[2:1] == 2'b11);
`else
    op_mul = (op[2:1] == 2'b01);
`endif
    op_sgn = ~op[0];
    a_neg  = op_sgn & a[WIDTH-1];
    b_neg  = op_sgn & b[WIDTH-1];
    a_mag  = a_neg ? -a : a;
    b_mag  = b_neg ? -b : b;
  end

  // Multiply: low half holds the multiplier, shifted out LSB first.
  // Divide: acc = {remainder, dividend/quotient}, restoring step per cycle.
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     trial, sub;
  logic               ge;
  logic [WIDTH-1:0]   rem_nxt;
  logic [2*WIDTH-1:0] step_nxt;
  logic               div_unused;

  always_comb begin
    addend  = acc[0] ? dsr : '0;
    add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    trial   = acc[2*WIDTH-1:WIDTH-1];
    sub     = trial - {1'b0, dsr};
    ge      = (trial >= {1'b0, dsr});
    rem_nxt = ge ? sub[WIDTH-1:0] : trial[WIDTH-1:0];
    if (is_div)
      step_nxt = {rem_nxt, acc[WIDTH-2:0], ge};
    else
      step_nxt = {add_sum, acc[WIDTH-1:1]};
  end

  assign div_unused = sub[WIDTH];

  logic [2*WIDTH-1:0] prod_res;
  logic [WIDTH-1:0]   quo_res, rem_res;

  always_comb begin
    prod_res = neg_res ? -acc : acc;
    quo_res  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_res  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      dsr      <= '0;
      is_div   <= 1'b0;
      is_acc   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      dz       <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (op == 3'b000) begin
              hi   <= a;
              done <= 1'b1;
            end else if (op == 3'b001) begin
              lo   <= a;
              done <= 1'b1;
            end else if (op_mul || op_div) begin
              acc     <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
              dsr     <= op_div ? b_mag : a_mag;
              is_div  <= op_div;
              is_acc  <= op[2] & op[1];
              neg_res <= a_neg ^ b_neg;
              neg_rem <= a_neg;
              cnt     <= '0;
              dz      <= op_div && (b == '0);
              state   <= (op_div && (b == '0)) ? FINISH : CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc <= step_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) state <= FINISH;
          end
        end
        FINISH: begin
          state <= IDLE;
          if (!flush) begin
            done <= 1'b1;
            if (dz)
              div_zero <= 1'b1;
            else if (is_div)
              {hi, lo} <= {rem_res, quo_res};
            else if (is_acc)
              {hi, lo} <= {hi, lo} + prod_res;
            else
              {hi, lo} <= prod_res;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hi_lo_muldiv_unit.sv
// Scoreboard bench for hi_lo_muldiv_unit (WIDTH=32); MADD checks follow HI_LO_MULDIV_MADD_EN.
module tb_hi_lo_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, flush;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  always #5 clk = ~clk;

  hi_lo_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_hi, m_lo;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    exp_t        e;
    logic [63:0] r, ua, ub;
    longint      sa, sb;
    int          qa, qb;
    e.hi = m_hi; e.lo = m_lo; e.dz = 1'b0;
    sa = {{32{av[31]}}, av};
    sb = {{32{bv[31]}}, bv};
    ua = {32'b0, av};
    ub = {32'b0, bv};
    r  = {m_hi, m_lo};
    case (o)
      3'd0: e.hi = av;
      3'd1: e.lo = av;
      3'd2: r = sa * sb;
      3'd3: r = ua * ub;
      3'd4: begin
        if (bv == 0) e.dz = 1'b1;
        else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
        else begin
          qa = av; qb = bv;
          r = {32'(qa % qb), 32'(qa / qb)};
        end
      end
      3'd5: begin
        if (bv == 0) e.dz = 1'b1;
        else r = {av % bv, av / bv};
      end
      3'd6: r = {m_hi, m_lo} + 64'(sa * sb);
      default: r = {m_hi, m_lo} + ua * ub;
    endcase
    if (o >= 3'd2) begin
      e.hi = r[63:32];
      e.lo = r[31:0];
    end
    return e;
  endfunction

  task automatic drive_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                          input logic fl, input bit push);
    exp_t e;
    if (push) begin
      e = model(o, av, bv);
      sb_q.push_back(e);
      m_hi = e.hi;
      m_lo = e.lo;
    end
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv; flush = fl;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    a = $urandom; b = $urandom; op = 3'($urandom);
  endtask

  task automatic wait_done(input string tag, input int exp_lat, input int exp_busy);
    int   n = 0;
    int   bc = 0;
    exp_t e;
    while (!done && n < 100) begin
      if (busy) bc++;
      @(posedge clk); #1;
      n++;
    end
    if (!done) begin
      check_val({tag, "_timeout"}, done, 1);
      return;
    end
    check_val({tag, "_lat"}, n, exp_lat);
    check_val({tag, "_busy_cycles"}, bc, exp_busy);
    check_val({tag, "_busy_at_done"}, busy, 0);
    check_val({tag, "_sb_nonempty"}, (sb_q.size() > 0), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val({tag, "_hi"}, hi, e.hi);
      check_val({tag, "_lo"}, lo, e.lo);
      check_val({tag, "_div_zero"}, div_zero, e.dz);
    end
    @(posedge clk); #1;
    check_val({tag, "_done_pulse"}, done, 0);
  endtask

  task automatic idle_watch(input int cyc, output int bc, output int dc);
    bc = 0; dc = 0;
    for (int i = 0; i < cyc; i++) begin
      @(posedge clk); #1;
      if (busy) bc++;
      if (done) dc++;
    end
  endtask

  initial begin
    int bc, dc;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    reset = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    m_hi = '0; m_lo = '0;
    #12;
    check_val("rst_hi", hi, 0);
    check_val("rst_lo", lo, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_div_zero", div_zero, 0);
    @(negedge clk); reset = 1'b1;

    drive_op(3'd0, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1); wait_done("mthi", 0, 0);
    drive_op(3'd1, 32'h1234_5678, 32'h0, 1'b0, 1'b1); wait_done("mtlo", 0, 0);
    drive_op(3'd2, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b1); wait_done("mult", 33, 33);
    drive_op(3'd3, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b1); wait_done("multu", 33, 33);
    drive_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1); wait_done("div_neg", 33, 33);
    drive_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1); wait_done("div_min", 33, 33);
    drive_op(3'd5, 32'd7, 32'd0, 1'b0, 1'b1); wait_done("divu_zero", 1, 1);

    // Starts while busy must be dropped without queueing.
    drive_op(3'd3, 32'h0001_0000, 32'h0003_0000, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); start = 1'b1; op = 3'd0; a = 32'd5;
      @(posedge clk); #1; start = 1'b0;
    end
    wait_done("busy_ignore", 30, 30);

    drive_op(3'd2, 32'h0000_1234, 32'h0000_5678, 1'b0, 1'b0);
    repeat (10) begin @(posedge clk); #1; end
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check_val("flush_busy", busy, 0);
    idle_watch(40, bc, dc);
    check_val("flush_no_done", dc, 0);
    check_val("flush_idle_busy", bc, 0);
    check_val("flush_hi", hi, m_hi);
    check_val("flush_lo", lo, m_lo);

    drive_op(3'd5, 32'd100, 32'd7, 1'b1, 1'b1); wait_done("flush_start_idle", 33, 33);

    for (int k = 0; k < 8; k++) begin
      ro = 3'(2 + $urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'h0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 300)));
      drive_op(ro, ra, rb, 1'b0, 1'b1);
      if (ro[2] && rb == 0) wait_done("rand_divz", 1, 1);
      else wait_done("rand", 33, 33);
    end

    drive_op(3'd2, 32'd123, 32'd456, 1'b0, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    @(negedge clk); reset = 1'b0;
    #1;
    check_val("midrst_hi", hi, 0);
    check_val("midrst_lo", lo, 0);
    check_val("midrst_busy", busy, 0);
    m_hi = '0; m_lo = '0;
    @(negedge clk); reset = 1'b1;
    idle_watch(40, bc, dc);
    check_val("postrst_busy", bc, 0);
    check_val("postrst_done", dc, 0);

    drive_op(3'd0, 32'h0, 32'h0, 1'b0, 1'b1); wait_done("madd_pre_hi", 0, 0);
    drive_op(3'd1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1); wait_done("madd_pre_lo", 0, 0);
`ifdef HI_LO_MULDIV_MADD_EN
    drive_op(3'd7, 32'd1, 32'd1, 1'b0, 1'b1); wait_done("maddu", 33, 33);
    drive_op(3'd6, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1); wait_done("madd", 33, 33);
`else
    drive_op(3'd7, 32'd1, 32'd1, 1'b0, 1'b0);
    idle_watch(40, bc, dc);
    check_val("maddu_off_busy", bc, 0);
    check_val("maddu_off_done", dc, 0);
    check_val("maddu_off_hi", hi, m_hi);
    check_val("maddu_off_lo", lo, m_lo);
`endif

    check_val("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
